// File: rtl/tl_a_queue_if.sv
// TileLink A-channel beat interface: valid/ready handshake plus all A fields.
// The producer side of a link uses the master modport, the consumer side the slave modport.
interface tl_a_queue_if;
  logic        valid;
  logic        ready;
  logic [2:0]  opcode;
  logic [2:0]  param;
  logic [3:0]  size;
  logic [6:0]  source;
  logic [29:0] address;
  logic [3:0]  mask;
  logic [31:0] data;
  logic        corrupt;

  modport master (
    output valid, opcode, param, size, source, address, mask, data, corrupt,
    input  ready
  );

  modport slave (
    input  valid, opcode, param, size, source, address, mask, data, corrupt,
    output ready
  );
endinterface

// File: rtl/tl_a_queue.sv
// TileLink A-channel queue: DEPTH-entry circular buffer with enq/deq pointers
// and a maybe_full flag that tells "full" from "empty" when the pointers meet.
// Optional macro TL_A_QUEUE_FLOW_EN: when the queue is empty an incoming beat
// is presented on deq in the same cycle, and skips storage if it is taken.
module tl_a_queue #(
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  tl_a_queue_if.slave  enq,
  tl_a_queue_if.master deq,
  output logic [4:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = 84;
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  logic [PW-1:0] r_enqPtr;
  logic [PW-1:0] r_deqPtr;
  logic          r_maybeFull;
  logic [BW-1:0] r_mem [DEPTH];

  logic          w_ptrMatch;
  logic          w_empty;
  logic          w_full;
  logic          w_doEnq;
  logic          w_doDeq;
  logic [BW-1:0] w_enqBeat;
  logic [BW-1:0] w_headBeat;
  logic [BW-1:0] w_outBeat;
  logic [4:0]    w_count;

  assign w_ptrMatch = (r_enqPtr == r_deqPtr);
  assign w_empty    = w_ptrMatch && !r_maybeFull;
  assign w_full     = w_ptrMatch && r_maybeFull;

  assign w_enqBeat  = {enq.opcode, enq.param, enq.size, enq.source,
                       enq.address, enq.mask, enq.data, enq.corrupt};
  assign w_headBeat = r_mem[r_deqPtr];

  assign enq.ready  = !w_full;

`ifdef TL_A_QUEUE_FLOW_EN
  assign deq.valid  = !w_empty || enq.valid;
  assign w_outBeat  = w_empty ? w_enqBeat : w_headBeat;
  assign w_doEnq    = enq.valid && !w_full && !(w_empty && deq.ready);
  assign w_doDeq    = !w_empty && deq.ready;
`else
  assign deq.valid  = !w_empty;
  assign w_outBeat  = w_headBeat;
  assign w_doEnq    = enq.valid && !w_full;
  assign w_doDeq    = !w_empty && deq.ready;
`endif

  assign {deq.opcode, deq.param, deq.size, deq.source,
          deq.address, deq.mask, deq.data, deq.corrupt} = w_outBeat;

  // Storage is written only on an accepted beat and is deliberately not reset.
  always_ff @(posedge clock) begin
    if (w_doEnq) begin
      r_mem[r_enqPtr] <= w_enqBeat;
    end
  end

  // Pointer and fullness tracking; pointers wrap by compare so DEPTH need not be a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_enqPtr    <= '0;
      r_deqPtr    <= '0;
      r_maybeFull <= 1'b0;
    end else begin
      if (w_doEnq) begin
        r_enqPtr <= (r_enqPtr == LAST_IDX) ? '0 : r_enqPtr + 1'b1;
      end
      if (w_doDeq) begin
        r_deqPtr <= (r_deqPtr == LAST_IDX) ? '0 : r_deqPtr + 1'b1;
      end
      if (w_doEnq != w_doDeq) begin
        r_maybeFull <= w_doEnq;
      end
    end
  end

  // Occupancy from pointer distance; meeting pointers mean DEPTH or 0 depending on maybe_full.
  always_comb begin
    w_count = '0;
    if (w_ptrMatch) begin
      w_count = r_maybeFull ? 5'(DEPTH) : 5'd0;
    end else if (r_enqPtr > r_deqPtr) begin
      w_count = 5'(r_enqPtr) - 5'(r_deqPtr);
    end else begin
      w_count = 5'(DEPTH) + 5'(r_enqPtr) - 5'(r_deqPtr);
    end
  end

  assign count = w_count;

endmodule

// File: doc/tl_a_queue.md
TL_A_QUEUE -- requirements
Module: tl_a_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 2: number of A-channel beat entries; legal range 1..16.
REQ-002 SHALL provide port clock  in  1: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset_n  in  1: reset, asynchronous, active-low.
REQ-004 SHALL provide port enq_valid  in  1: upstream beat present.
REQ-005 SHALL provide port enq_ready  out  1: an entry is free.
REQ-006 SHALL provide ports enq_opcode in 3, enq_param in 3, enq_size in 4, enq_source in 7, enq_address in 30, enq_mask in 4, enq_data in 32, enq_corrupt in 1: TileLink A-channel fields.
REQ-007 SHALL provide port deq_valid  out  1: head entry present.
REQ-008 SHALL provide port deq_ready  in  1: downstream (TL monitor/consumer) accepts head.
REQ-009 SHALL provide ports deq_opcode out 3, deq_param out 3, deq_size out 4, deq_source out 7, deq_address out 30, deq_mask out 4, deq_data out 32, deq_corrupt out 1: head entry fields.
REQ-010 SHALL provide port count  out  5: current occupancy, 0..DEPTH.

Function
REQ-011 SHALL store entries in a DEPTH-entry circular buffer indexed by enq_ptr and deq_ptr, plus a maybe_full flag.
REQ-012 SHALL define empty = (enq_ptr == deq_ptr) && !maybe_full and full = (enq_ptr == deq_ptr) && maybe_full.
REQ-013 SHALL drive enq_ready = !full and deq_valid = !empty; neither SHALL depend combinationally on the opposite side's valid/ready.
REQ-014 SHALL on do_enq (enq_valid && enq_ready) write all enq fields to entry enq_ptr and advance enq_ptr.
REQ-015 SHALL on do_deq (deq_valid && deq_ready) advance deq_ptr; deq fields SHALL always show entry deq_ptr.
REQ-016 SHALL wrap each pointer from DEPTH-1 to 0 by explicit compare (no power-of-two requirement).
REQ-017 SHALL set maybe_full <= do_enq whenever do_enq != do_deq; otherwise hold.
REQ-018 SHALL, on simultaneous do_enq and do_deq, keep count unchanged and advance both pointers.
REQ-019 SHALL give enqueue-to-dequeue latency of 1 cycle: a beat accepted at edge N is visible with deq_valid=1 after edge N.
REQ-020 SHALL hold deq fields stable while deq_valid && !deq_ready.
REQ-021 SHALL compute count as occupancy from pointers and maybe_full, DEPTH when full, 0 when empty, with no overflow past DEPTH.
REQ-022 SHALL NOT modify any field (address, mask, data, corrupt) in transit.

Reset
REQ-023 SHALL on reset_n low clear enq_ptr, deq_ptr, maybe_full immediately: deq_valid=0, enq_ready=1, count=0.
REQ-024 SHALL NOT reset the storage array; deq field values are don't-care while deq_valid=0.
REQ-025 SHALL discard all buffered beats on reset mid-operation; first post-reset deq SHALL be the first post-reset enq.

Configuration
REQ-026 SHALL support macro TL_A_QUEUE_FLOW_EN; when defined and the queue is empty, deq_valid=enq_valid and deq fields=enq fields combinationally (0-cycle latency); if deq_ready is also 1 that cycle the beat SHALL bypass storage (no write, pointers and count unchanged).
REQ-027 SHALL, without TL_A_QUEUE_FLOW_EN, keep deq_valid=0 whenever empty regardless of enq_valid (REQ-019 latency).

Verification
REQ-028 SHALL cover: reset, then DEPTH=2, enq beats source=0x05 and 0x06 with deq_ready=0 -> count=2, enq_ready=0, deq_source=0x05.
REQ-029 SHALL cover: full queue, enq_valid=1 and deq_ready=1 same cycle -> 0x05 dequeued, new beat not accepted, count=1, then deq_source=0x06.
REQ-030 SHALL cover: count=1, simultaneous enq (address=0x3FFF_FFFC) and deq for 8 cycles -> count stays 1, pointers wrap, order preserved.
REQ-031 SHALL cover: empty, enq_valid=1 with deq_ready=1 -> without macro deq_valid=0 that cycle, beat appears next cycle; with TL_A_QUEUE_FLOW_EN deq_valid=1 same cycle, count stays 0.
REQ-032 SHALL cover: count=2, reset_n pulsed low mid-cycle -> deq_valid=0, enq_ready=1, count=0 immediately, no stale beat after release.
REQ-033 SHALL cover: deq_ready held 0 for 5 cycles with deq_valid=1 -> all deq fields (data=0xDEADBEEF, mask=0xF, corrupt=0) constant.
